// File: rtl/serial_mem_pkg.sv
// ============================================================================
// serial_mem_pkg - shared types and constants for the serial memory bridge
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_mem_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] CMD_READ  = 32'd0;
  localparam logic [WORD_W-1:0] CMD_WRITE = 32'd1;

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_WDATA = 3'd3,
    S_WREQ  = 3'd4,
    S_RREQ  = 3'd5,
    S_RWAIT = 3'd6,
    S_RSEND = 3'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_mem_bridge.sv
// ============================================================================
// serial_mem_bridge - host command words to single-outstanding memory bursts
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_mem_bridge
  import serial_mem_pkg::*;
#(
  parameter logic [WORD_W-1:0] ADDR_STEP = 32'd4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              serial_in_valid,
  output logic              serial_in_ready,
  input  logic [WORD_W-1:0] serial_in_bits,
  output logic              serial_out_valid,
  input  logic              serial_out_ready,
  output logic [WORD_W-1:0] serial_out_bits,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [WORD_W-1:0] mem_req_addr,
  output logic [WORD_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [WORD_W-1:0] mem_resp_data,
  output logic              err
);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] obuf_q, obuf_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_CMD;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      obuf_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      obuf_q  <= obuf_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    obuf_d  = obuf_q;
    wdata_d = wdata_q;

    // Only RWAIT may legally see a response, including the request-handshake cycle.
    if (mem_resp_valid && (state_q != S_RWAIT)) err_d = 1'b1;

    case (state_q)
      S_CMD: begin
        if (serial_in_valid) begin
          if (serial_in_bits == CMD_READ) begin
            wr_d    = 1'b0;
            state_d = S_ADDR;
          end else if (serial_in_bits == CMD_WRITE) begin
            wr_d    = 1'b1;
            state_d = S_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (serial_in_valid) begin
          addr_d  = serial_in_bits;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (serial_in_valid) begin
          cnt_d   = serial_in_bits;
          state_d = wr_q ? S_WDATA : S_RREQ;
        end
      end
      S_WDATA: begin
        if (serial_in_valid) begin
          wdata_d = serial_in_bits;
          state_d = S_WREQ;
        end
      end
      S_WREQ: begin
        if (mem_req_ready) begin
          if (cnt_q == '0) begin
            state_d = S_CMD;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            addr_d  = addr_q + ADDR_STEP;
            state_d = S_WDATA;
          end
        end
      end
      S_RREQ: begin
        if (mem_req_ready) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (mem_resp_valid) begin
          obuf_d  = mem_resp_data;
          state_d = S_RSEND;
        end
      end
      S_RSEND: begin
        if (serial_out_ready) begin
          if (cnt_q == '0) begin
            state_d = S_CMD;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            addr_d  = addr_q + ADDR_STEP;
            state_d = S_RREQ;
          end
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  assign serial_in_ready  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                            (state_q == S_LEN) || (state_q == S_WDATA);
  assign mem_req_valid    = (state_q == S_WREQ) || (state_q == S_RREQ);
  assign mem_req_write    = (state_q == S_WREQ);
  assign mem_req_addr     = addr_q;
  assign mem_req_wdata    = (state_q == S_WREQ) ? wdata_q : '0;
  assign serial_out_valid = (state_q == S_RSEND);
  assign serial_out_bits  = obuf_q;
  assign err              = err_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_mem_bridge.sv
// ============================================================================
// tb_serial_mem_bridge - directed self-checking bench for serial_mem_bridge
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_mem_bridge;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        serial_in_valid = 1'b0;
  logic        serial_in_ready;
  logic [31:0] serial_in_bits = '0;
  logic        serial_out_valid;
  logic        serial_out_ready = 1'b0;
  logic [31:0] serial_out_bits;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  serial_mem_bridge #(.ADDR_STEP(32'd4)) dut (
    .clock(clock), .reset_n(reset_n),
    .serial_in_valid(serial_in_valid), .serial_in_ready(serial_in_ready),
    .serial_in_bits(serial_in_bits),
    .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready),
    .serial_out_bits(serial_out_bits),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int waited = 0;
    serial_in_valid = 1'b1;
    serial_in_bits  = w;
    while (!serial_in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("send_ready_timeout", 32'(waited < 20), 32'd1);
    tick();
    serial_in_valid = 1'b0;
    serial_in_bits  = '0;
  endtask

  // Starts in RREQ; issues one read, returns data a cycle later, drains it.
  task automatic read_word(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
    check({tag, "_req_write"}, 32'(mem_req_write), 32'd0);
    check({tag, "_req_addr"}, mem_req_addr, exp_addr);
    check({tag, "_req_wdata"}, mem_req_wdata, 32'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, "_rwait_novalid"}, 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    check({tag, "_out_valid"}, 32'(serial_out_valid), 32'd1);
    check({tag, "_out_bits"}, serial_out_bits, data);
    serial_out_ready = 1'b1;
    tick();
    serial_out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values.
    reset_n = 1'b0;
    tick();
    check("rst_in_ready", 32'(serial_in_ready), 32'd1);
    check("rst_out_valid", 32'(serial_out_valid), 32'd0);
    check("rst_out_bits", serial_out_bits, 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick();

    // READ burst of three words.
    send_word(32'd0);
    send_word(32'h1000);
    send_word(32'd2);
    read_word("rd0", 32'h1000, 32'hA);
    read_word("rd1", 32'h1004, 32'hB);
    read_word("rd2", 32'h1008, 32'hC);
    check("rd_done_cmd", 32'(serial_in_ready), 32'd1);
    check("rd_done_noreq", 32'(mem_req_valid), 32'd0);
    check("rd_err", 32'(err), 32'd0);

    // WRITE burst, first request stalled three cycles.
    send_word(32'd1);
    send_word(32'h2000);
    send_word(32'd1);
    send_word(32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      check("wr0_valid", 32'(mem_req_valid), 32'd1);
      check("wr0_write", 32'(mem_req_write), 32'd1);
      check("wr0_addr", mem_req_addr, 32'h2000);
      check("wr0_wdata", mem_req_wdata, 32'hDEAD);
      check("wr0_in_ready", 32'(serial_in_ready), 32'd0);
      check("wr0_no_out", 32'(serial_out_valid), 32'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("wr_wdata_state", 32'(serial_in_ready), 32'd1);
    send_word(32'hBEEF);
    check("wr1_write", 32'(mem_req_write), 32'd1);
    check("wr1_addr", mem_req_addr, 32'h2004);
    check("wr1_wdata", mem_req_wdata, 32'hBEEF);
    check("wr1_in_ready", 32'(serial_in_ready), 32'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("wr_done_cmd", 32'(serial_in_ready), 32'd1);
    check("wr_done_noreq", 32'(mem_req_valid), 32'd0);
    check("wr_no_out", 32'(serial_out_valid), 32'd0);

    // Address wrap with output backpressure.
    send_word(32'd0);
    send_word(32'hFFFF_FFFC);
    send_word(32'd1);
    check("wrap0_addr", mem_req_addr, 32'hFFFF_FFFC);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1111_2222;
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("wrap_stall_valid", 32'(serial_out_valid), 32'd1);
      check("wrap_stall_bits", serial_out_bits, 32'h1111_2222);
      tick();
    end
    serial_out_ready = 1'b1;
    tick();
    serial_out_ready = 1'b0;
    read_word("wrap1", 32'h0000_0000, 32'h3333_4444);
    check("wrap_done_cmd", 32'(serial_in_ready), 32'd1);
    check("wrap_err", 32'(err), 32'd0);

    // Bad command word sets err and is dropped.
    send_word(32'd7);
    check("badcmd_err", 32'(err), 32'd1);
    check("badcmd_in_cmd", 32'(serial_in_ready), 32'd1);
    send_word(32'd0);
    send_word(32'h10);
    send_word(32'd0);
    read_word("after_err", 32'h10, 32'h55);
    check("after_err_cmd", 32'(serial_in_ready), 32'd1);

    // Spurious response in CMD.
    apply_reset();
    check("spur_err_cleared", 32'(err), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h99;
    tick();
    mem_resp_valid = 1'b0;
    check("spur_err", 32'(err), 32'd1);
    check("spur_no_out", 32'(serial_out_valid), 32'd0);
    check("spur_in_cmd", 32'(serial_in_ready), 32'd1);

    // Reset in RSEND of a four-word read.
    apply_reset();
    send_word(32'd0);
    send_word(32'h100);
    send_word(32'd3);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h77;
    tick();
    mem_resp_valid = 1'b0;
    check("mid_rsend", 32'(serial_out_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_in_ready", 32'(serial_in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(serial_out_valid), 32'd0);
    check("mid_rst_out_bits", serial_out_bits, 32'd0);
    check("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("mid_rst_req_write", 32'(mem_req_write), 32'd0);
    check("mid_rst_req_addr", mem_req_addr, 32'd0);
    check("mid_rst_req_wdata", mem_req_wdata, 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_cmd", 32'(serial_in_ready), 32'd1);
    check("post_rst_noreq", 32'(mem_req_valid), 32'd0);
    send_word(32'd0);
    send_word(32'h40);
    send_word(32'd0);
    read_word("post_rst", 32'h40, 32'h1234_5678);
    check("post_rst_done", 32'(serial_in_ready), 32'd1);
    check("post_rst_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
